// File: rtl/spi_host_bridge_pkg.sv
// Shared opcodes and FSM state encoding for the SPI host bridge.
package spi_host_bridge_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_CLRERR = 8'hFF;

  localparam int unsigned DUMMY_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_ADDR,
    ST_WDATA,
    ST_WBUS,
    ST_RDUMMY,
    ST_RDATA,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/pad_sync_edge.sv
// N-stage synchroniser for an asynchronous pad input, with registered
// rise/fall strobes (N+1 clk from pad edge to strobe).
module pad_sync_edge #(
  parameter int unsigned N       = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pad,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [N-1:0] r_sync;
  logic         r_prev;
  logic         r_rise;
  logic         r_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {N{RST_VAL}};
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[N-2:0], i_pad};
      r_prev <= r_sync[N-1];
      r_rise <= r_sync[N-1] & ~r_prev;
      r_fall <= ~r_sync[N-1] & r_prev;
    end
  end

  assign o_level = r_sync[N-1];
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/spi_host_bridge.sv
// SPI mode-0 slave that turns command frames into single-word bus transactions.
// Optional feature: define SPI_BRIDGE_AUTOINC_EN for address auto-increment bursts.
module spi_host_bridge
  import spi_host_bridge_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pad_sclk,
  input  logic          pad_csn,
  input  logic          pad_mosi,
  output logic          pad_miso,
  output logic          pad_miso_oe,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          err
);

  localparam int unsigned SW = (AW > DW) ? ((AW > 8) ? AW : 8) : ((DW > 8) ? DW : 8);
  localparam int unsigned CW = $clog2(SW + 16);

  logic w_sclk_rise, w_sclk_fall, w_unused_sclk_lvl;
  logic w_csn_lvl, w_csn_rise, w_csn_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_mosi;

  pad_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(clk), .i_rst(rst), .i_pad(pad_sclk),
    .o_level(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  pad_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .i_clk(clk), .i_rst(rst), .i_pad(pad_csn),
    .o_level(w_csn_lvl), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) r_mosi_sync <= '0;
    else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], pad_mosi};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [SW-2:0]   r_shift;
  logic [SW-1:0]   w_shift_word;
  logic [7:0]      r_opc;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rd;
  logic [DW-2:0]   r_oshift;
  logic            r_req, r_we, r_have, r_err, r_miso, r_abort;

  logic w_shift, w_cnt_inc, w_cnt_clr, w_ld_opc, w_ld_addr, w_issue_wr, w_issue_rd;
  logic w_addr_inc, w_ld_rd, w_shift_out, w_clr_err, w_set_err, w_abort, w_ack;
  logic w_rd_have;
  logic [DW-1:0] w_rd_word;

  assign w_shift_word = {r_shift, w_mosi};
  assign w_ack        = bus_ack & r_req;
  assign w_rd_have    = r_have | (w_ack & ~r_we);
  assign w_rd_word    = r_have ? r_rd : ((w_ack & ~r_we) ? bus_rdata : '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_ld_opc    = 1'b0;
    w_ld_addr   = 1'b0;
    w_issue_wr  = 1'b0;
    w_issue_rd  = 1'b0;
    w_addr_inc  = 1'b0;
    w_ld_rd     = 1'b0;
    w_shift_out = 1'b0;
    w_clr_err   = 1'b0;
    w_set_err   = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_csn_fall) begin
        w_state_nxt = ST_OPC;
        w_cnt_clr   = 1'b1;
      end
      ST_OPC: if (w_sclk_rise) begin
        w_shift   = 1'b1;
        w_cnt_inc = 1'b1;
        if (r_cnt == CW'(7)) begin
          w_cnt_clr = 1'b1;
          w_ld_opc  = 1'b1;
          case (w_shift_word[7:0])
            OP_WRITE, OP_READ: w_state_nxt = ST_ADDR;
            OP_CLRERR: begin
              w_clr_err   = 1'b1;
              w_state_nxt = ST_DRAIN;
            end
            default: begin
              w_set_err   = 1'b1;
              w_state_nxt = ST_DRAIN;
            end
          endcase
        end
      end
      ST_ADDR: if (w_sclk_rise) begin
        w_shift   = 1'b1;
        w_cnt_inc = 1'b1;
        if (r_cnt == CW'(AW - 1)) begin
          w_cnt_clr = 1'b1;
          w_ld_addr = 1'b1;
          if (r_opc == OP_READ) begin
            w_issue_rd  = 1'b1;
            w_state_nxt = ST_RDUMMY;
          end else begin
            w_state_nxt = ST_WDATA;
          end
        end
      end
      ST_WDATA: if (w_sclk_rise) begin
        w_shift   = 1'b1;
        w_cnt_inc = 1'b1;
        if (r_cnt == CW'(DW - 1)) begin
          w_cnt_clr   = 1'b1;
          w_issue_wr  = 1'b1;
          w_state_nxt = ST_WBUS;
        end
      end
      ST_WBUS: begin
        // keep collecting the next burst word while the bus is still busy
        if (w_sclk_rise) begin
          w_shift   = 1'b1;
          w_cnt_inc = 1'b1;
        end
        if (w_ack) begin
`ifdef SPI_BRIDGE_AUTOINC_EN
          w_addr_inc  = 1'b1;
          w_state_nxt = ST_WDATA;
`else
          w_state_nxt = ST_DRAIN;
`endif
        end
      end
      ST_RDUMMY: begin
        if (w_sclk_rise) w_cnt_inc = 1'b1;
        if (w_sclk_fall && r_cnt == CW'(DUMMY_BITS)) begin
          w_cnt_clr   = 1'b1;
          w_ld_rd     = 1'b1;
          w_state_nxt = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (w_sclk_fall) w_shift_out = 1'b1;
        if (w_sclk_rise) begin
          w_cnt_inc = 1'b1;
          if (r_cnt == CW'(DW - 1)) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_DRAIN;
`ifdef SPI_BRIDGE_AUTOINC_EN
            if (!r_req) begin
              w_addr_inc  = 1'b1;
              w_issue_rd  = 1'b1;
              w_state_nxt = ST_RDUMMY;
            end
`endif
          end
        end
      end
      ST_DRAIN: if (!r_req) begin
        if (w_csn_lvl) begin
          w_state_nxt = ST_IDLE;
        end else if (r_abort) begin
          w_state_nxt = ST_OPC;
          w_cnt_clr   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // CSn rise anywhere mid-frame overrides the per-state decision above
    if (w_csn_rise && r_state != ST_IDLE && r_state != ST_DRAIN) begin
      w_abort     = 1'b1;
      w_issue_wr  = 1'b0;
      w_issue_rd  = 1'b0;
      w_addr_inc  = 1'b0;
      w_ld_rd     = 1'b0;
      w_state_nxt = (r_req && !w_ack) ? ST_DRAIN : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_opc    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd     <= '0;
      r_oshift <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_have   <= 1'b0;
      r_err    <= 1'b0;
      r_miso   <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
      if (w_shift)  r_shift <= w_shift_word[SW-2:0];
      if (w_ld_opc) r_opc   <= w_shift_word[7:0];
      if (w_ld_addr)       r_addr <= w_shift_word[AW-1:0];
      else if (w_addr_inc) r_addr <= r_addr + AW'(1);
      if (w_ack) begin
        r_req <= 1'b0;
        if (!r_we) begin
          r_rd   <= bus_rdata;
          r_have <= 1'b1;
        end
      end
      if (w_issue_wr) begin
        r_req   <= 1'b1;
        r_we    <= 1'b1;
        r_wdata <= w_shift_word[DW-1:0];
      end
      if (w_issue_rd) begin
        r_req  <= 1'b1;
        r_we   <= 1'b0;
        r_have <= 1'b0;
      end
      if (w_set_err || (w_ld_rd && !w_rd_have)) r_err <= 1'b1;
      else if (w_clr_err)                      r_err <= 1'b0;
      if (w_ld_rd) begin
        r_miso   <= w_rd_word[DW-1];
        r_oshift <= w_rd_word[DW-2:0];
      end else if (w_shift_out) begin
        r_miso   <= r_oshift[DW-2];
        r_oshift <= {r_oshift[DW-3:0], 1'b0};
      end
      if (w_state_nxt != ST_RDATA) r_miso <= 1'b0;
      r_abort <= (w_state_nxt == ST_DRAIN) & (r_abort | w_abort);
    end
  end

  assign pad_miso_oe = ((r_state == ST_RDUMMY) || (r_state == ST_RDATA)) & ~w_csn_lvl;
  assign pad_miso    = pad_miso_oe & r_miso;
  assign bus_req     = r_req;
  assign bus_we      = r_we;
  assign bus_addr    = r_addr;
  assign bus_wdata   = r_wdata;
  assign err         = r_err;

endmodule

// File: tb/tb_spi_host_bridge.sv
// Self-checking bench: bit-banged SPI host, scoreboarded bus responder.
module tb_spi_host_bridge;
  import spi_host_bridge_pkg::*;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;
  localparam int unsigned HALF = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          pad_sclk, pad_csn, pad_mosi;
  logic          pad_miso, pad_miso_oe;
  logic          bus_req, bus_we, bus_ack, err;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          exp_bus[$];
  logic [DW-1:0] exp_miso[$];
  int            checks = 0;
  int            errors = 0;
  int            n_bus = 0;
  int            ack_delay = 3;
  logic          ack_hold = 1'b0;
  logic [DW-1:0] rd_value = '0;

  always #5 clk = ~clk;

  spi_host_bridge #(.AW(AW), .DW(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .pad_sclk(pad_sclk), .pad_csn(pad_csn), .pad_mosi(pad_mosi),
    .pad_miso(pad_miso), .pad_miso_oe(pad_miso_oe),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .err(err)
  );

  // Bus slave: checks each new request against the scoreboard, acks after a delay.
  initial begin : responder
    int   wait_cnt;
    logic seen;
    txn_t e;
    bus_ack = 1'b0; bus_rdata = '0; seen = 1'b0; wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus_req !== 1'b1) begin
        seen = 1'b0;
      end else begin
        if (!seen) begin
          seen = 1'b1; wait_cnt = 0; n_bus++;
          checks++;
          if (exp_bus.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected: got we=%0b addr=%h wdata=%h, required no request",
                     bus_we, bus_addr, bus_wdata);
          end else begin
            e = exp_bus.pop_front();
            if (bus_we !== e.we || bus_addr !== e.addr || (e.we && bus_wdata !== e.wdata)) begin
              errors++;
              $display("FAIL bus_txn: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                       bus_we, bus_addr, bus_wdata, e.we, e.addr, e.wdata);
            end
          end
        end
        if (!ack_hold && wait_cnt >= ack_delay) begin
          bus_ack = 1'b1; bus_rdata = rd_value;
          @(negedge clk);
          bus_ack = 1'b0; bus_rdata = '0; seen = 1'b0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic csn_low();
    #1 pad_csn = 1'b0;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic csn_high();
    repeat (HALF) @(posedge clk);
    #1 pad_csn = 1'b1;
    repeat (4 * HALF) @(posedge clk);
  endtask

  // Shifts n bits MSB first; captures MISO and OE just before each rising edge.
  task automatic spi_bits(input logic [127:0] tx, input int n, input int release_at,
                          output logic [127:0] rx_miso, output logic [127:0] rx_oe);
    rx_miso = '0; rx_oe = '0;
    for (int i = 0; i < n; i++) begin
      pad_mosi = tx[n-1-i];
      if (i == release_at) ack_hold = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
      rx_miso[n-1-i] = pad_miso;
      rx_oe[n-1-i]   = pad_miso_oe;
      pad_sclk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1 pad_sclk = 1'b0;
    end
  endtask

  task automatic wait_no_req(input string name);
    int k = 0;
    while (bus_req === 1'b1 && k < 200) begin
      @(posedge clk); k++;
    end
    #1;
    checks++;
    if (bus_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_req_timeout: got bus_req=%b, required 0 within 200 clk", name, bus_req);
    end
  endtask

  task automatic clrerr_frame();
    logic [127:0] tx, rx, oe;
    tx = '0; tx[7:0] = OP_CLRERR;
    csn_low(); spi_bits(tx, 8, -1, rx, oe); csn_high();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL clrerr: got err=%b, required 0", err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pad_sclk = 1'b0; pad_csn = 1'b1; pad_mosi = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_req, bus_we, pad_miso, pad_miso_oe, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got req/we/miso/oe/err=%b, required 00000",
                         {bus_req, bus_we, pad_miso, pad_miso_oe, err});
    end
    checks++;
    if (bus_addr !== '0 || bus_wdata !== '0) begin
      errors++; $display("FAIL reset_bus: got addr=%h wdata=%h, required 0", bus_addr, bus_wdata);
    end
    checks++;
    if (dut.r_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d, required IDLE", dut.r_state);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
    logic [127:0] tx, rx, oe;
    int nb;
    nb = n_bus;
    tx = '0; tx[55:0] = {OP_WRITE, a, d};
    exp_bus.push_back('{we: 1'b1, addr: a, wdata: d});
    csn_low(); spi_bits(tx, 56, -1, rx, oe); csn_high();
    wait_no_req(name);
    checks++;
    if (n_bus - nb != 1 || exp_bus.size() != 0) begin
      errors++; $display("FAIL %s_count: got %0d requests (%0d pending), required 1", name, n_bus - nb, exp_bus.size());
    end
    checks++;
    if (err !== 1'b0 || oe[55:0] !== 56'h0) begin
      errors++; $display("FAIL %s_err_oe: got err=%b oe=%h, required err=0 oe=0", name, err, oe[55:0]);
    end
  endtask

  task automatic test_write();
    ack_delay = 3;
    do_write(16'h0123, 32'hCAFEF00D, "write");
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] rv, input logic late,
                         input string name);
    logic [127:0] tx, rx, oe;
    logic [DW-1:0] e;
    rd_value = rv;
    ack_hold = late;
    tx = '0; tx[63:0] = {OP_READ, a, 8'h00, 32'h0};
    exp_bus.push_back('{we: 1'b0, addr: a, wdata: '0});
    exp_miso.push_back(late ? '0 : rv);
    csn_low(); spi_bits(tx, 64, late ? 36 : -1, rx, oe); csn_high();
    wait_no_req(name);
    e = exp_miso.pop_front();
    checks++;
    if (rx[31:0] !== e || rx[63:32] !== 32'h0) begin
      errors++; $display("FAIL %s_miso: got %h, required %h", name, rx[63:0], {32'h0, e});
    end
    checks++;
    if (oe[63:0] !== 64'h000000FF_FFFFFFFF || pad_miso_oe !== 1'b0) begin
      errors++; $display("FAIL %s_oe: got %h idle=%b, required 000000ffffffffff idle=0", name, oe[63:0], pad_miso_oe);
    end
    checks++;
    if (err !== late || exp_bus.size() != 0) begin
      errors++; $display("FAIL %s_err: got err=%b pending=%0d, required err=%b pending=0", name, err, exp_bus.size(), late);
    end
  endtask

  task automatic test_read();
    ack_delay = 5;
    do_read(16'h0040, 32'h12345678, 1'b0, "read");
  endtask

  task automatic test_read_late();
    ack_delay = 1;
    do_read(16'h0077, 32'hDEADBEEF, 1'b1, "read_late");
    clrerr_frame();
  endtask

  task automatic test_bad_opcode();
    logic [127:0] tx, rx, oe;
    int nb;
    nb = n_bus;
    tx = '0; tx[23:0] = {8'h55, 16'h1234};
    csn_low(); spi_bits(tx, 24, -1, rx, oe); csn_high();
    checks++;
    if (err !== 1'b1 || n_bus != nb) begin
      errors++; $display("FAIL bad_opcode: got err=%b requests=%0d, required err=1 requests=0", err, n_bus - nb);
    end
    clrerr_frame();
  endtask

  task automatic test_abort();
    logic [127:0] tx, rx, oe;
    int nb;
    nb = n_bus;
    tx = '0; tx[43:0] = {OP_WRITE, 16'h0200, 20'hABCDE};
    csn_low(); spi_bits(tx, 44, -1, rx, oe); csn_high();
    checks++;
    if (n_bus != nb || dut.r_state !== ST_IDLE) begin
      errors++; $display("FAIL abort: got requests=%0d state=%0d, required 0 and IDLE", n_bus - nb, dut.r_state);
    end
  endtask

  task automatic test_back_to_back();
    ack_delay = 0;
    do_write(16'h0201, 32'h0BADC0DE, "b2b_write");
    ack_delay = 2;
    do_read(16'h0201, 32'hA5A55A5A, 1'b0, "b2b_read");
  endtask

  task automatic test_two_words();
    logic [127:0] tx, rx, oe;
    int nb, want;
    logic [AW-1:0] a;
    ack_delay = 3;
    nb = n_bus;
`ifdef SPI_BRIDGE_AUTOINC_EN
    a = 16'hFFFF;
    exp_bus.push_back('{we: 1'b1, addr: 16'hFFFF, wdata: 32'h11112222});
    exp_bus.push_back('{we: 1'b1, addr: 16'h0000, wdata: 32'h33334444});
    want = 2;
`else
    a = 16'h0010;
    exp_bus.push_back('{we: 1'b1, addr: 16'h0010, wdata: 32'h11112222});
    want = 1;
`endif
    tx = '0; tx[87:0] = {OP_WRITE, a, 32'h11112222, 32'h33334444};
    csn_low(); spi_bits(tx, 88, -1, rx, oe); csn_high();
    wait_no_req("two_words");
    checks++;
    if (n_bus - nb != want || exp_bus.size() != 0 || rx[87:0] !== 88'h0) begin
      errors++; $display("FAIL two_words: got %0d requests pending=%0d miso=%h, required %0d pending=0 miso=0",
                         n_bus - nb, exp_bus.size(), rx[87:0], want);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_late();
    test_bad_opcode();
    test_abort();
    test_back_to_back();
    test_two_words();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
